// File: rtl/countdown_if.sv
// Keypad/display-side signal bundle for the countdown timer core.
// The master drives load digits and run controls; the slave (the timer)
// drives back the current time and status flags.
interface countdown_if;
  logic [3:0] bin0;
  logic [3:0] bin1;
  logic [3:0] bin2;
  logic [3:0] bin3;
  logic       load;
  logic       start;
  logic       pause;
  logic [3:0] dig0;
  logic [3:0] dig1;
  logic [3:0] dig2;
  logic [3:0] dig3;
  logic       running;
  logic       done;
  logic       alarm;

  modport master (
    output bin0, bin1, bin2, bin3, load, start, pause,
    input  dig0, dig1, dig2, dig3, running, done, alarm
  );

  modport slave (
    input  bin0, bin1, bin2, bin3, load, start, pause,
    output dig0, dig1, dig2, dig3, running, done, alarm
  );
endinterface

// File: rtl/countdown.sv
// Kitchen-timer countdown core: holds MM:SS as four BCD digits, decrements
// once per prescaler wrap (TICK_DIV clk cycles), with IDLE/RUN/PAUSE/DONE
// run control and a done/alarm flag.
// Build option: define ALARM_BLINK_EN to make alarm toggle on every
// prescaler wrap while in DONE; otherwise alarm is held steadily high.
module countdown #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input logic        clk,
  input logic        rst_n,
  countdown_if.slave bus
);

  localparam int unsigned PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state;
  logic [15:0]     tm;       // {dig3, dig2, dig1, dig0}
  logic [PW-1:0]   presc;
  logic            running;
  logic            done;
  logic            alarm;

  logic [15:0]     load_val;
  logic [15:0]     tm_dec;
  logic            tick;

  // Saturate a BCD digit to an upper limit (9 for most digits, 5 for seconds tens).
  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  // One-second decrement with a BCD borrow chain: ss ones, ss tens (0..5),
  // mm ones, then mm tens. Never applied to 00:00.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] d0;
    logic [3:0] d1;
    logic [3:0] d2;
    logic [3:0] d3;
    logic       b;
    d0 = t[3:0];
    d1 = t[7:4];
    d2 = t[11:8];
    d3 = t[15:12];
    b  = (d0 == 4'd0);
    d0 = b ? 4'd9 : d0 - 4'd1;
    if (b) begin
      b  = (d1 == 4'd0);
      d1 = b ? 4'd5 : d1 - 4'd1;
    end
    if (b) begin
      b  = (d2 == 4'd0);
      d2 = b ? 4'd9 : d2 - 4'd1;
    end
    if (b) begin
      d3 = d3 - 4'd1;
    end
    return {d3, d2, d1, d0};
  endfunction

  assign load_val = {clamp_digit(bus.bin3, 4'd9), clamp_digit(bus.bin2, 4'd9),
                     clamp_digit(bus.bin1, 4'd5), clamp_digit(bus.bin0, 4'd9)};
  assign tm_dec   = bcd_dec(tm);
  assign tick     = (presc == PW'(TICK_DIV - 1));

  // Run-control FSM: time register, prescaler and registered status flags.
  // Priority each cycle is load > pause > start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tm      <= '0;
      presc   <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      alarm   <= 1'b0;
    end else if (bus.load) begin
      state   <= IDLE;
      tm      <= load_val;
      presc   <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      alarm   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          presc <= '0;
          if (!bus.pause && bus.start && (tm != 16'h0000)) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (bus.pause) begin
            // Prescaler is intentionally left as-is so resume finishes the second.
            state   <= PAUSE;
            running <= 1'b0;
          end else if (tick) begin
            presc <= '0;
            tm    <= tm_dec;
            if (tm_dec == 16'h0000) begin
              state   <= DONE;
              running <= 1'b0;
              done    <= 1'b1;
              alarm   <= 1'b1;
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end
        PAUSE: begin
          if (!bus.pause && bus.start) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        DONE: begin
          tm <= '0;
`ifdef ALARM_BLINK_EN
          // Keep the prescaler free-running so alarm forms a square wave.
          if (tick) begin
            presc <= '0;
            alarm <= ~alarm;
          end else begin
            presc <= presc + 1'b1;
          end
`else
          presc <= '0;
          alarm <= 1'b1;
`endif
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
          done    <= 1'b0;
          alarm   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dig0    = tm[3:0];
  assign bus.dig1    = tm[7:4];
  assign bus.dig2    = tm[11:8];
  assign bus.dig3    = tm[15:12];
  assign bus.running = running;
  assign bus.done    = done;
  assign bus.alarm   = alarm;

endmodule

// File: tb/tb_countdown.sv
// Bench for the countdown timer core at TICK_DIV=4. Stimulus pushes the
// expected output vector {dig3,dig2,dig1,dig0,running,done,alarm} into a
// scoreboard queue; a monitor pops and compares on each falling clk edge.
module tb_countdown;

  logic clk = 1'b0;
  logic rst_n;

  countdown_if bif ();

  countdown #(.TICK_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  always #5 clk = ~clk;

`ifdef ALARM_BLINK_EN
  localparam logic BLINK = 1'b1;
`else
  localparam logic BLINK = 1'b0;
`endif

  int total  = 0;
  int passed = 0;

  string       nameq[$];
  logic [18:0] expq[$];

  task automatic expect_out(input string nm, input logic [3:0] d3, input logic [3:0] d2,
                            input logic [3:0] d1, input logic [3:0] d0,
                            input logic r, input logic dn, input logic al);
    nameq.push_back(nm);
    expq.push_back({d3, d2, d1, d0, r, dn, al});
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [3:0] b3, input logic [3:0] b2,
                         input logic [3:0] b1, input logic [3:0] b0);
    bif.bin3 = b3;
    bif.bin2 = b2;
    bif.bin1 = b1;
    bif.bin0 = b0;
    bif.load = 1'b1;
    step(1);
    bif.load = 1'b0;
  endtask

  task automatic pulse_start();
    bif.start = 1'b1;
    step(1);
    bif.start = 1'b0;
  endtask

  // Monitor: compare every queued expectation against the live outputs.
  initial begin
    string       nm;
    logic [18:0] ex;
    logic [18:0] act;
    forever begin
      @(negedge clk);
      while (expq.size() > 0) begin
        nm  = nameq.pop_front();
        ex  = expq.pop_front();
        act = {bif.dig3, bif.dig2, bif.dig1, bif.dig0, bif.running, bif.done, bif.alarm};
        total++;
        if (act === ex) begin
          passed++;
        end else begin
          $display("FAIL %s: got %h%h:%h%h run=%b done=%b alarm=%b, required %h%h:%h%h run=%b done=%b alarm=%b",
                   nm, act[18:15], act[14:11], act[10:7], act[6:3], act[2], act[1], act[0],
                   ex[18:15], ex[14:11], ex[10:7], ex[6:3], ex[2], ex[1], ex[0]);
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    bif.bin0  = 4'd0;
    bif.bin1  = 4'd0;
    bif.bin2  = 4'd0;
    bif.bin3  = 4'd0;
    bif.load  = 1'b0;
    bif.start = 1'b0;
    bif.pause = 1'b0;

    expect_out("reset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    step(1);

    // 00:10 countdown to expiry
    do_load(0, 0, 1, 0);
    expect_out("load_0010", 0, 0, 1, 0, 0, 0, 0);
    pulse_start();
    expect_out("start_run", 0, 0, 1, 0, 1, 0, 0);
    step(4);
    expect_out("first_tick", 0, 0, 0, 9, 1, 0, 0);
    step(3);
    expect_out("presc_hold", 0, 0, 0, 9, 1, 0, 0);
    step(29);
    expect_out("last_second", 0, 0, 0, 1, 1, 0, 0);
    step(3);
    expect_out("last_presc", 0, 0, 0, 1, 1, 0, 0);
    step(1);
    expect_out("expire_10", 0, 0, 0, 0, 0, 1, 1);

    // DONE ignores start; alarm behaviour depends on build option
    bif.start = 1'b1;
    step(3);
    expect_out("done_hold", 0, 0, 0, 0, 0, 1, 1);
    step(1);
    expect_out("done_alarm4", 0, 0, 0, 0, 0, 1, !BLINK);
    step(4);
    expect_out("done_alarm8", 0, 0, 0, 0, 0, 1, 1'b1);
    bif.start = 1'b0;

    // 01:00 -> 00:59, then expiry after 60 ticks
    do_load(0, 1, 0, 0);
    expect_out("load_0100", 0, 1, 0, 0, 0, 0, 0);
    pulse_start();
    step(4);
    expect_out("min_borrow", 0, 0, 5, 9, 1, 0, 0);
    step(232);
    expect_out("min_last", 0, 0, 0, 1, 1, 0, 0);
    step(4);
    expect_out("min_expire", 0, 0, 0, 0, 0, 1, 1);

    // 10:00 -> 09:59, then load mid-run returns to IDLE
    do_load(1, 0, 0, 0);
    expect_out("load_1000", 1, 0, 0, 0, 0, 0, 0);
    pulse_start();
    step(4);
    expect_out("ten_borrow", 0, 9, 5, 9, 1, 0, 0);
    step(2);
    do_load(0, 0, 0, 5);
    expect_out("load_in_run", 0, 0, 0, 5, 0, 0, 0);
    step(6);
    expect_out("idle_frozen", 0, 0, 0, 5, 0, 0, 0);

    // Full prescaler period after restart, then pause/resume
    pulse_start();
    step(3);
    expect_out("restart_p3", 0, 0, 0, 5, 1, 0, 0);
    step(1);
    expect_out("restart_tick", 0, 0, 0, 4, 1, 0, 0);
    step(2);
    bif.pause = 1'b1;
    bif.start = 1'b1;
    step(1);
    expect_out("pause_enter", 0, 0, 0, 4, 0, 0, 0);
    step(19);
    expect_out("pause_hold", 0, 0, 0, 4, 0, 0, 0);
    bif.pause = 1'b0;
    step(1);
    expect_out("resume", 0, 0, 0, 4, 1, 0, 0);
    bif.start = 1'b0;
    step(1);
    expect_out("resume_p3", 0, 0, 0, 4, 1, 0, 0);
    step(1);
    expect_out("resume_tick", 0, 0, 0, 3, 1, 0, 0);

    // Clamping of out-of-range digits
    do_load(11, 3, 7, 12);
    expect_out("clamp", 9, 3, 5, 9, 0, 0, 0);
    pulse_start();
    step(4);
    expect_out("clamp_run", 9, 3, 5, 8, 1, 0, 0);

    // Start with 00:00 stays IDLE
    do_load(0, 0, 0, 0);
    expect_out("zero_load", 0, 0, 0, 0, 0, 0, 0);
    bif.start = 1'b1;
    step(2);
    expect_out("zero_start", 0, 0, 0, 0, 0, 0, 0);
    bif.start = 1'b0;

    // Reach DONE, then reload clears done and alarm
    do_load(0, 0, 0, 1);
    pulse_start();
    step(4);
    expect_out("one_expire", 0, 0, 0, 0, 0, 1, 1);
    do_load(0, 0, 0, 3);
    expect_out("done_reload", 0, 0, 0, 3, 0, 0, 0);

    // Asynchronous reset between clock edges mid-run
    pulse_start();
    step(2);
    #2 rst_n = 1'b0;
    expect_out("async_rst", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    step(5);
    expect_out("post_rst", 0, 0, 0, 0, 0, 0, 0);

    step(2);
    if (expq.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d pending expectations, required 0", expq.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
